// File: rtl/rvfi_shadow_rf_mon.sv
// Shadow register-file monitor for the ibex RVFI retirement stream: rebuilds
// GPR state from retired writebacks and cross-checks every rs1/rs2 read value.
module rvfi_shadow_rf_mon #(
  parameter int unsigned CNT_W       = 32,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             rvfi_valid,
  input  logic             rvfi_trap,
  input  logic [31:0]      rvfi_insn,
  input  logic [4:0]       rvfi_rs1_addr,
  input  logic [4:0]       rvfi_rs2_addr,
  input  logic [31:0]      rvfi_rs1_rdata,
  input  logic [31:0]      rvfi_rs2_rdata,
  input  logic [4:0]       rvfi_rd_addr,
  input  logic [31:0]      rvfi_rd_wdata,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic             err_o,
  output logic [1:0]       err_src_o,
  output logic [31:0]      err_insn_o,
  output logic [4:0]       err_reg_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FAULT = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [31:0][31:0]  shadow_q, shadow_d;
  logic [31:0]        known_q, known_d;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0]   mismatch_cnt_q, mismatch_cnt_d;
  logic               err_q, err_d;
  logic [1:0]         err_src_q, err_src_d;
  logic [31:0]        err_insn_q, err_insn_d;
  logic [4:0]         err_reg_q, err_reg_d;

  logic accept, do_check, rs1_mis, rs2_mis, mismatch;

  // x0 is permanently "known" with shadow value 0, so x0 reads need no special case.
  assign accept   = rvfi_valid && !clear_i && (state_q != S_FAULT);
  assign do_check = accept && !rvfi_trap;
  assign rs1_mis  = do_check && known_q[rvfi_rs1_addr] &&
                    (shadow_q[rvfi_rs1_addr] != rvfi_rs1_rdata);
  assign rs2_mis  = do_check && known_q[rvfi_rs2_addr] &&
                    (shadow_q[rvfi_rs2_addr] != rvfi_rs2_rdata);
  assign mismatch = rs1_mis || rs2_mis;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d        = state_q;
    shadow_d       = shadow_q;
    known_d        = known_q;
    retire_cnt_d   = retire_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    err_d          = err_q;
    err_src_d      = err_src_q;
    err_insn_d     = err_insn_q;
    err_reg_d      = err_reg_q;

    if (clear_i) begin
      state_d        = S_IDLE;
      known_d        = 32'h0000_0001;
      retire_cnt_d   = '0;
      mismatch_cnt_d = '0;
      err_d          = 1'b0;
      err_src_d      = '0;
      err_insn_d     = '0;
      err_reg_d      = '0;
    end else if (accept) begin
      if (retire_cnt_q != '1) retire_cnt_d = retire_cnt_q + CNT_W'(1);
      if (mismatch && (mismatch_cnt_q != '1)) mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
      if (mismatch && !err_q) begin
        err_d      = 1'b1;
        err_src_d  = {rs2_mis, rs1_mis};
        err_insn_d = rvfi_insn;
        err_reg_d  = rs1_mis ? rvfi_rs1_addr : rvfi_rs2_addr;
      end
      // Checks above used the pre-update shadow, so rs==rd sees the old value.
      if (do_check && (rvfi_rd_addr != 5'd0)) begin
        shadow_d[rvfi_rd_addr] = rvfi_rd_wdata;
        known_d[rvfi_rd_addr]  = 1'b1;
      end
      state_d = (mismatch && STOP_ON_ERR) ? S_FAULT : S_RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      // NOTE: the shadow array is reset too so x0 is guaranteed to read as 0.
      shadow_q       <= '0;
      known_q        <= 32'h0000_0001;
      retire_cnt_q   <= '0;
      mismatch_cnt_q <= '0;
      err_q          <= 1'b0;
      err_src_q      <= '0;
      err_insn_q     <= '0;
      err_reg_q      <= '0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      known_q        <= known_d;
      retire_cnt_q   <= retire_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      err_q          <= err_d;
      err_src_q      <= err_src_d;
      err_insn_q     <= err_insn_d;
      err_reg_q      <= err_reg_d;
    end
  end

  assign retire_cnt_o   = retire_cnt_q;
  assign mismatch_cnt_o = mismatch_cnt_q;
  assign err_o          = err_q;
  assign err_src_o      = err_src_q;
  assign err_insn_o     = err_insn_q;
  assign err_reg_o      = err_reg_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_rvfi_shadow_rf_mon.sv
// Directed bench for rvfi_shadow_rf_mon: three instances (stop-on-error, keep-going,
// 2-bit counters) share the RVFI data fields; each has its own valid and clear.
module tb_rvfi_shadow_rf_mon;

  typedef enum int {F_RET, F_MIS, F_ERR, F_SRC, F_INSN, F_REG, F_STATE} fld_e;
  typedef struct {
    string       tag;
    int          inst;
    fld_e        fld;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  valid = '0;
  logic [2:0]  clear = '0;
  logic        trap = 1'b0;
  logic [31:0] insn = '0;
  logic [4:0]  rs1a = '0, rs2a = '0, rda = '0;
  logic [31:0] rs1d = '0, rs2d = '0, wd = '0;

  logic [31:0] ret_o [2];
  logic [31:0] mis_o [2];
  logic        err_o [3];
  logic [1:0]  src_o [3];
  logic [31:0] insn_o [3];
  logic [4:0]  reg_o [3];
  logic [1:0]  st_o [3];
  logic [1:0]  ret_c2, mis_c2;

  always #5 clk = ~clk;

  rvfi_shadow_rf_mon #(.CNT_W(32), .STOP_ON_ERR(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear[0]), .rvfi_valid(valid[0]),
    .rvfi_trap(trap), .rvfi_insn(insn), .rvfi_rs1_addr(rs1a), .rvfi_rs2_addr(rs2a),
    .rvfi_rs1_rdata(rs1d), .rvfi_rs2_rdata(rs2d), .rvfi_rd_addr(rda), .rvfi_rd_wdata(wd),
    .retire_cnt_o(ret_o[0]), .mismatch_cnt_o(mis_o[0]), .err_o(err_o[0]),
    .err_src_o(src_o[0]), .err_insn_o(insn_o[0]), .err_reg_o(reg_o[0]), .state_o(st_o[0]));

  rvfi_shadow_rf_mon #(.CNT_W(32), .STOP_ON_ERR(1'b0)) dut_ns (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear[1]), .rvfi_valid(valid[1]),
    .rvfi_trap(trap), .rvfi_insn(insn), .rvfi_rs1_addr(rs1a), .rvfi_rs2_addr(rs2a),
    .rvfi_rs1_rdata(rs1d), .rvfi_rs2_rdata(rs2d), .rvfi_rd_addr(rda), .rvfi_rd_wdata(wd),
    .retire_cnt_o(ret_o[1]), .mismatch_cnt_o(mis_o[1]), .err_o(err_o[1]),
    .err_src_o(src_o[1]), .err_insn_o(insn_o[1]), .err_reg_o(reg_o[1]), .state_o(st_o[1]));

  rvfi_shadow_rf_mon #(.CNT_W(2), .STOP_ON_ERR(1'b1)) dut_c2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear[2]), .rvfi_valid(valid[2]),
    .rvfi_trap(trap), .rvfi_insn(insn), .rvfi_rs1_addr(rs1a), .rvfi_rs2_addr(rs2a),
    .rvfi_rs1_rdata(rs1d), .rvfi_rs2_rdata(rs2d), .rvfi_rd_addr(rda), .rvfi_rd_wdata(wd),
    .retire_cnt_o(ret_c2), .mismatch_cnt_o(mis_c2), .err_o(err_o[2]),
    .err_src_o(src_o[2]), .err_insn_o(insn_o[2]), .err_reg_o(reg_o[2]), .state_o(st_o[2]));

  function automatic logic [31:0] obs(int inst, fld_e f);
    logic [31:0] v;
    v = '0;
    case (f)
      F_RET:   v = (inst == 2) ? {30'd0, ret_c2} : ret_o[inst];
      F_MIS:   v = (inst == 2) ? {30'd0, mis_c2} : mis_o[inst];
      F_ERR:   v = {31'd0, err_o[inst]};
      F_SRC:   v = {30'd0, src_o[inst]};
      F_INSN:  v = insn_o[inst];
      F_REG:   v = {27'd0, reg_o[inst]};
      F_STATE: v = {30'd0, st_o[inst]};
      default: v = 'x;
    endcase
    return v;
  endfunction

  task automatic push(string tag, int inst, fld_e f, logic [31:0] v);
    exp_t e;
    e.tag = tag; e.inst = inst; e.fld = f; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_q();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.inst, e.fld);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic push_all_zero(string tag, int inst);
    push({tag, "_ret"}, inst, F_RET, 0);
    push({tag, "_mis"}, inst, F_MIS, 0);
    push({tag, "_err"}, inst, F_ERR, 0);
    push({tag, "_src"}, inst, F_SRC, 0);
    push({tag, "_insn"}, inst, F_INSN, 0);
    push({tag, "_reg"}, inst, F_REG, 0);
    push({tag, "_st"}, inst, F_STATE, 0);
  endtask

  // One retirement on instance `inst`, then compare everything queued for it.
  task automatic retire(int inst, logic t, logic [31:0] iw, logic [4:0] a1, logic [31:0] d1,
                        logic [4:0] a2, logic [31:0] d2, logic [4:0] rd, logic [31:0] w,
                        logic clr);
    trap = t; insn = iw; rs1a = a1; rs1d = d1; rs2a = a2; rs2d = d2; rda = rd; wd = w;
    valid[inst] = 1'b1;
    clear[inst] = clr;
    @(posedge clk);
    #1;
    valid = '0;
    clear = '0;
    check_q();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    push_all_zero("rst", 0);
    push_all_zero("rst_ns", 1);
    check_q();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write x5, read it back in the very next instruction.
    push("w5_ret", 0, F_RET, 1); push("w5_st", 0, F_STATE, 1);
    retire(0, 0, 32'h0000_0013, 5'd0, 0, 5'd0, 0, 5'd5, 32'h0000_1234, 0);
    push("r5_ret", 0, F_RET, 2); push("r5_err", 0, F_ERR, 0); push("r5_st", 0, F_STATE, 1);
    retire(0, 0, 32'h0000_0113, 5'd5, 32'h0000_1234, 5'd0, 0, 5'd0, 0, 0);

    // Never-written x7 is not flagged.
    push("r7_err", 0, F_ERR, 0); push("r7_ret", 0, F_RET, 3);
    retire(0, 0, 32'h0000_0213, 5'd7, 32'hDEAD_BEEF, 5'd0, 0, 5'd0, 0, 0);

    // rs1 == rd: compare against old value, new value visible next instruction.
    push("w3_ret", 0, F_RET, 4);
    retire(0, 0, 32'h0000_0313, 5'd0, 0, 5'd0, 0, 5'd3, 32'd5, 0);
    push("rsrd_err", 0, F_ERR, 0); push("rsrd_ret", 0, F_RET, 5);
    retire(0, 0, 32'h0011_8193, 5'd3, 32'd5, 5'd0, 0, 5'd3, 32'd6, 0);
    push("r3new_err", 0, F_ERR, 0);
    retire(0, 0, 32'h0000_0413, 5'd3, 32'd6, 5'd0, 0, 5'd0, 0, 0);

    // Trapped insn with a bad rs1 value and rd=x3: counted, unchecked, no write.
    push("trap_ret", 0, F_RET, 7); push("trap_err", 0, F_ERR, 0); push("trap_mis", 0, F_MIS, 0);
    retire(0, 1, 32'h0000_0073, 5'd3, 32'h777, 5'd0, 0, 5'd3, 32'd9, 0);
    push("post_trap_err", 0, F_ERR, 0); push("post_trap_ret", 0, F_RET, 8);
    retire(0, 0, 32'h0000_0513, 5'd3, 32'd6, 5'd0, 0, 5'd0, 0, 0);

    // rs2 mismatch freezes the stop-on-error instance.
    retire(0, 0, 32'h0000_0613, 5'd0, 0, 5'd0, 0, 5'd5, 32'h10, 0);
    push("m_err", 0, F_ERR, 1); push("m_src", 0, F_SRC, 2'b10); push("m_reg", 0, F_REG, 5);
    push("m_insn", 0, F_INSN, 32'hABCD_0033); push("m_mis", 0, F_MIS, 1);
    push("m_st", 0, F_STATE, 2); push("m_ret", 0, F_RET, 10);
    retire(0, 0, 32'hABCD_0033, 5'd0, 0, 5'd5, 32'h11, 5'd0, 0, 0);
    push("frz_ret", 0, F_RET, 10); push("frz_mis", 0, F_MIS, 1);
    push("frz_insn", 0, F_INSN, 32'hABCD_0033); push("frz_st", 0, F_STATE, 2);
    retire(0, 0, 32'h1111_0033, 5'd5, 32'h99, 5'd0, 0, 5'd6, 32'h1, 0);

    // clear_i beats rvfi_valid: the instruction is dropped, everything returns to 0.
    push_all_zero("clr", 0);
    retire(0, 0, 32'h2222_0033, 5'd0, 32'd1, 5'd0, 0, 5'd5, 32'h99, 1);
    push("unk5_err", 0, F_ERR, 0); push("unk5_ret", 0, F_RET, 1); push("unk5_st", 0, F_STATE, 1);
    retire(0, 0, 32'h0000_0713, 5'd5, 32'h999, 5'd3, 32'h333, 5'd0, 0, 0);

    // x0 read with nonzero data.
    push("x0_err", 0, F_ERR, 1); push("x0_src", 0, F_SRC, 2'b01); push("x0_reg", 0, F_REG, 0);
    push("x0_insn", 0, F_INSN, 32'h0000_0893); push("x0_st", 0, F_STATE, 2);
    push("x0_ret", 0, F_RET, 2);
    retire(0, 0, 32'h0000_0893, 5'd0, 32'd1, 5'd0, 0, 5'd0, 0, 0);

    // Keep-going instance: first mismatch hits both rs1 (x4) and rs2 (x0).
    retire(1, 0, 32'h0000_0A13, 5'd0, 0, 5'd0, 0, 5'd4, 32'h44, 0);
    push("ns1_mis", 1, F_MIS, 1); push("ns1_src", 1, F_SRC, 2'b11); push("ns1_reg", 1, F_REG, 4);
    retire(1, 0, 32'hA000_0001, 5'd4, 32'h45, 5'd0, 32'd5, 5'd0, 0, 0);
    push("ns2_mis", 1, F_MIS, 2); push("ns2_st", 1, F_STATE, 1);
    retire(1, 0, 32'hA000_0002, 5'd4, 32'h46, 5'd0, 0, 5'd0, 0, 0);
    push("ns3_mis", 1, F_MIS, 3); push("ns3_insn", 1, F_INSN, 32'hA000_0001);
    push("ns3_src", 1, F_SRC, 2'b11); push("ns3_st", 1, F_STATE, 1); push("ns3_ret", 1, F_RET, 4);
    retire(1, 0, 32'hA000_0003, 5'd4, 32'h47, 5'd0, 0, 5'd0, 0, 0);

    // 2-bit counters saturate at 3.
    for (int i = 0; i < 5; i++) begin
      push($sformatf("sat_ret%0d", i), 2, F_RET, (i < 3) ? i + 1 : 3);
      retire(2, 0, 32'h0000_0013, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    end

    // Asynchronous reset mid-stream, then the next retirement is the first.
    rst_n = 1'b0;
    #2;
    push_all_zero("arst", 0);
    push("arst_c2_ret", 2, F_RET, 0);
    check_q();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push("post_rst_ret", 0, F_RET, 1); push("post_rst_st", 0, F_STATE, 1);
    push("post_rst_err", 0, F_ERR, 0);
    retire(0, 0, 32'h0000_0B13, 5'd5, 32'h1234, 5'd0, 0, 5'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
